// File: rtl/bl_mode_mux_ramp_if.sv
// Bus bundle for the backlight mode mux: command input, frame timing,
// the two block-statistics sample streams and the processed output stream.
interface bl_mode_mux_ramp_if #(
    parameter int DW  = 8,
    parameter int CH  = 3,
    parameter int VCW = 6
);
    logic                 cmd_valid;
    logic [7:0]           cmd_code;
    logic [31:0]          para_list;
    logic                 frame_start;
    logic [DW-1:0]        mean_white;
    logic [VCW-1:0]       v_cnt_white;
    logic                 valid_white;
    logic [CH*DW-1:0]     mean_color;
    logic [VCW-1:0]       v_cnt_color;
    logic                 valid_color;
    logic [CH*DW-1:0]     block_mean;
    logic [VCW-1:0]       block_v_cnt;
    logic                 data_valid;
    logic [1:0]           mode_active;
    logic                 ramp_busy;
    logic                 cmd_err;

    // Producer side: command source, frame timing and statistics generators
    modport master (
        output cmd_valid, cmd_code, para_list, frame_start,
        output mean_white, v_cnt_white, valid_white,
        output mean_color, v_cnt_color, valid_color,
        input  block_mean, block_v_cnt, data_valid, mode_active, ramp_busy, cmd_err
    );

    // Mux side
    modport slave (
        input  cmd_valid, cmd_code, para_list, frame_start,
        input  mean_white, v_cnt_white, valid_white,
        input  mean_color, v_cnt_color, valid_color,
        output block_mean, block_v_cnt, data_valid, mode_active, ramp_busy, cmd_err
    );
endinterface

// File: rtl/bl_mode_mux_ramp.sv
// Backlight-mode mux: frame-synchronous command commit, per-frame ramping of
// the working values, and a 2-stage subtract/scale datapath toward the LED driver.
module bl_mode_mux_ramp #(
    parameter int DW        = 8,
    parameter int CH        = 3,
    parameter int VCW       = 6,
    parameter int RAMP_STEP = 4
) (
    input logic               clk,
    input logic               rstn,
    bl_mode_mux_ramp_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_A0 = 2'd0,
        MODE_A1 = 2'd1,
        MODE_A2 = 2'd2
    } mode_t;

    localparam int            PW   = CH * DW;
    localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);

    mode_t          mode_reg, pend_mode_reg, s1_mode_reg, cmd_mode;
    logic           pend_reg, cmd_ok, commit, mode_change;
    logic [PW-1:0]  pend_para_reg, tgt_reg, cur_reg, tgt_next, cur_next;
    logic [CH-1:0]  busy_vec;
    logic           ramp_busy_reg, cmd_err_reg;
    logic           sel_valid, s1_valid_reg, data_valid_reg;
    logic [PW-1:0]  sel_mean, s1_mean_reg, s2_vec, block_mean_reg;
    logic [VCW-1:0] sel_vcnt, s1_vcnt_reg, block_v_cnt_reg;
    logic           unused_para;

    assign unused_para = ^bus.para_list[31:PW];

    // Decode the three known command codes into a mode
    always_comb begin
        cmd_ok   = 1'b0;
        cmd_mode = MODE_A0;
        case (bus.cmd_code)
            8'hA0:   begin cmd_ok = 1'b1; cmd_mode = MODE_A0; end
            8'hA1:   begin cmd_ok = 1'b1; cmd_mode = MODE_A1; end
            8'hA2:   begin cmd_ok = 1'b1; cmd_mode = MODE_A2; end
            default: begin cmd_ok = 1'b0; cmd_mode = MODE_A0; end
        endcase
    end

    // A pending command only lands on a frame boundary
    assign commit      = bus.frame_start & pend_reg;
    assign mode_change = commit & (pend_mode_reg != mode_reg);

    for (genvar gi = 0; gi < CH; gi++) begin : g_ramp
        logic [DW-1:0] tgt_c, cur_c, tgt_n, cur_n;
        assign tgt_c = tgt_reg[gi*DW +: DW];
        assign cur_c = cur_reg[gi*DW +: DW];

        // Commit reloads the target; A0 uses the low byte on every channel
        always_comb begin
            tgt_n = tgt_c;
            if (commit)
                tgt_n = (pend_mode_reg == MODE_A0) ? pend_para_reg[DW-1:0]
                                                   : pend_para_reg[gi*DW +: DW];
        end

        // Jump on a mode switch, otherwise step toward the target without overshoot
        always_comb begin
            cur_n = cur_c;
            if (bus.frame_start) begin
                if (mode_change)
                    cur_n = tgt_n;
                else if (tgt_n > cur_c)
                    cur_n = ((tgt_n - cur_c) > STEP) ? cur_c + STEP : tgt_n;
                else if (tgt_n < cur_c)
                    cur_n = ((cur_c - tgt_n) > STEP) ? cur_c - STEP : tgt_n;
            end
        end

        assign tgt_next[gi*DW +: DW] = tgt_n;
        assign cur_next[gi*DW +: DW] = cur_n;
        assign busy_vec[gi]          = (cur_n != tgt_n);
    end

    // Command capture, commit, and working-value state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_reg      <= 1'b0;
            pend_mode_reg <= MODE_A0;
            pend_para_reg <= '0;
            mode_reg      <= MODE_A0;
            tgt_reg       <= '0;
            cur_reg       <= '0;
            ramp_busy_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
        end else begin
            cmd_err_reg <= bus.cmd_valid & ~cmd_ok;
            if (bus.cmd_valid && cmd_ok) begin
                pend_reg      <= 1'b1;
                pend_mode_reg <= cmd_mode;
                pend_para_reg <= bus.para_list[PW-1:0];
            end else if (commit) begin
                pend_reg <= 1'b0;
            end
            if (commit)
                mode_reg <= pend_mode_reg;
            tgt_reg       <= tgt_next;
            cur_reg       <= cur_next;
            ramp_busy_reg <= |busy_vec;
        end
    end

    // A2 takes the colour stream; A0/A1 take the white stream
    always_comb begin
        sel_valid = bus.valid_white;
        sel_mean  = PW'(bus.mean_white);
        sel_vcnt  = bus.v_cnt_white;
        if (mode_reg == MODE_A2) begin
            sel_valid = bus.valid_color;
            sel_mean  = bus.mean_color;
            sel_vcnt  = bus.v_cnt_color;
        end
    end

    // Stage 1: capture the sample together with the mode it will be processed in
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= MODE_A0;
            s1_mean_reg  <= '0;
            s1_vcnt_reg  <= '0;
        end else begin
            s1_valid_reg <= sel_valid;
            if (sel_valid) begin
                s1_mode_reg <= mode_reg;
                s1_mean_reg <= sel_mean;
                s1_vcnt_reg <= sel_vcnt;
            end
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_s2
        logic [DW-1:0]   w, c, cur_c, cur_0, res;
        logic [2*DW-1:0] prod;
        assign w     = s1_mean_reg[DW-1:0];
        assign c     = s1_mean_reg[gi*DW +: DW];
        assign cur_c = cur_reg[gi*DW +: DW];
        assign cur_0 = cur_reg[DW-1:0];
        assign prod  = {{DW{1'b0}}, w} * {{DW{1'b0}}, cur_c};

        // Per-channel saturating subtract or ratio scale
        always_comb begin
            res = '0;
            case (s1_mode_reg)
                MODE_A0: res = (w > cur_0) ? w - cur_0 : '0;
                MODE_A1: res = DW'(prod >> DW);
                default: res = (c > cur_c) ? c - cur_c : '0;
            endcase
        end

        assign s2_vec[gi*DW +: DW] = res;
    end

    // Stage 2: register the result; value and row hold between pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_valid_reg  <= 1'b0;
            block_mean_reg  <= '0;
            block_v_cnt_reg <= '0;
        end else begin
            data_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                block_mean_reg  <= s2_vec;
                block_v_cnt_reg <= s1_vcnt_reg;
            end
        end
    end

    assign bus.block_mean  = block_mean_reg;
    assign bus.block_v_cnt = block_v_cnt_reg;
    assign bus.data_valid  = data_valid_reg;
    assign bus.mode_active = mode_reg;
    assign bus.ramp_busy   = ramp_busy_reg;
    assign bus.cmd_err     = cmd_err_reg;
endmodule

// File: tb/tb_bl_mode_mux_ramp.sv
// Scoreboard bench for bl_mode_mux_ramp: stimulus pushes hand-computed expected
// outputs, a negedge monitor pops and compares on every data_valid.
module tb_bl_mode_mux_ramp;
    localparam int DW  = 8;
    localparam int CH  = 3;
    localparam int VCW = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bl_mode_mux_ramp_if #(.DW(DW), .CH(CH), .VCW(VCW)) bus();

    bl_mode_mux_ramp #(.DW(DW), .CH(CH), .VCW(VCW), .RAMP_STEP(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [23:0] mean;
        logic [5:0]  vcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] t3_exp  [4] = '{8'hCB, 8'hC7, 8'hC3, 8'hBF};
    logic       t3_busy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] code, input logic [31:0] para);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = code;
        bus.para_list = para;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_white(input logic [7:0] m, input logic [5:0] v,
                              input bit expect_out, input logic [23:0] e);
        exp_t t;
        bus.mean_white  = m;
        bus.v_cnt_white = v;
        bus.valid_white = 1'b1;
        if (expect_out) begin
            t.mean = e;
            t.vcnt = v;
            exp_q.push_back(t);
        end
        tick();
        bus.valid_white = 1'b0;
    endtask

    task automatic send_color(input logic [23:0] m, input logic [5:0] v,
                              input bit expect_out, input logic [23:0] e);
        exp_t t;
        bus.mean_color  = m;
        bus.v_cnt_color = v;
        bus.valid_color = 1'b1;
        if (expect_out) begin
            t.mean = e;
            t.vcnt = v;
            exp_q.push_back(t);
        end
        tick();
        bus.valid_color = 1'b0;
    endtask

    // Monitor: every output pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rstn && bus.data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got mean=%06h vcnt=%0d, required no output",
                         bus.block_mean, bus.block_v_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_mean", 32'(bus.block_mean), 32'(mon_e.mean));
                check("out_vcnt", 32'(bus.block_v_cnt), 32'(mon_e.vcnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_code    = 8'h00;
        bus.para_list   = 32'h0;
        bus.frame_start = 1'b0;
        bus.mean_white  = '0;
        bus.v_cnt_white = '0;
        bus.valid_white = 1'b0;
        bus.mean_color  = '0;
        bus.v_cnt_color = '0;
        bus.valid_color = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_mean",  32'(bus.block_mean),  32'h0);
        check("rst_dv",    32'(bus.data_valid),  32'h0);
        check("rst_mode",  32'(bus.mode_active), 32'h0);
        check("rst_busy",  32'(bus.ramp_busy),   32'h0);
        check("rst_err",   32'(bus.cmd_err),     32'h0);
        rstn = 1'b1;
        tick();

        // White passthrough and 2-cycle latency
        send_white(8'h80, 6'd1, 1'b1, 24'h808080);
        check("lat_n1", 32'(bus.data_valid), 32'h0);
        tick();
        check("lat_n2", 32'(bus.data_valid), 32'h1);
        check("mode_a0", 32'(bus.mode_active), 32'h0);
        tick();
        check("dv_pulse", 32'(bus.data_valid), 32'h0);

        // A0 0x30: no effect before frame_start, then ramps 4 per frame
        cmd(8'hA0, 32'h30);
        send_white(8'h80, 6'd2, 1'b1, 24'h808080);
        repeat (2) tick();
        frame();
        check("t2_busy_f1", 32'(bus.ramp_busy), 32'h1);
        repeat (11) frame();
        check("t2_busy_f12", 32'(bus.ramp_busy), 32'h0);
        send_white(8'h80, 6'd3, 1'b1, 24'h505050);
        send_white(8'h20, 6'd4, 1'b1, 24'h000000);
        repeat (3) tick();

        // A0 0x30 -> 0x40 over four frames, then non-overshooting steps
        cmd(8'hA0, 32'h40);
        for (int i = 0; i < 4; i++) begin
            frame();
            check("t3_busy", 32'(bus.ramp_busy), 32'(t3_busy[i]));
            send_white(8'hFF, 6'(10 + i), 1'b1, {3{t3_exp[i]}});
        end
        cmd(8'hA0, 32'h42);
        frame();
        check("t3_busy_up2", 32'(bus.ramp_busy), 32'h0);
        send_white(8'hFF, 6'd20, 1'b1, 24'hBDBDBD);
        cmd(8'hA0, 32'h3F);
        frame();
        send_white(8'hFF, 6'd21, 1'b1, 24'hC0C0C0);
        repeat (3) tick();

        // A1 tint: mode switch jumps, colour stream ignored
        cmd(8'hA1, 32'h00FF0080);
        frame();
        check("t4_mode", 32'(bus.mode_active), 32'h1);
        check("t4_busy", 32'(bus.ramp_busy), 32'h0);
        send_white(8'h80, 6'd6, 1'b1, 24'h7F0040);
        send_color(24'h123456, 6'd7, 1'b0, 24'h0);
        repeat (3) tick();

        // A2 colour dim: only colour stream produces output
        cmd(8'hA2, 32'h00102030);
        frame();
        check("t5_mode", 32'(bus.mode_active), 32'h2);
        send_color(24'h0830FF, 6'd5, 1'b1, 24'h0010CF);
        send_white(8'h80, 6'd8, 1'b0, 24'h0);
        repeat (3) tick();

        // Unknown code pulses cmd_err and leaves the pending A1 intact
        cmd(8'hA1, 32'h00404040);
        cmd(8'h55, 32'h00FFFFFF);
        check("t6_err_on", 32'(bus.cmd_err), 32'h1);
        tick();
        check("t6_err_off", 32'(bus.cmd_err), 32'h0);
        frame();
        check("t6_mode_a1", 32'(bus.mode_active), 32'h1);
        send_white(8'h80, 6'd9, 1'b1, 24'h202020);
        repeat (3) tick();

        // Command in the same cycle as frame_start waits for the next frame
        cmd(8'hA0, 32'h10);
        bus.frame_start = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_code    = 8'hA2;
        bus.para_list   = 32'h00202020;
        tick();
        bus.frame_start = 1'b0;
        bus.cmd_valid   = 1'b0;
        check("t6_mode_old", 32'(bus.mode_active), 32'h0);
        send_white(8'h80, 6'd10, 1'b1, 24'h707070);
        frame();
        check("t6_mode_new", 32'(bus.mode_active), 32'h2);
        send_color(24'h30FF05, 6'd11, 1'b1, 24'h10DF00);
        repeat (3) tick();

        // Reset while a sample is in flight: pipeline cleared, no stray output
        send_color(24'h808080, 6'd12, 1'b0, 24'h0);
        rstn = 1'b0;
        #1;
        check("mr_dv",   32'(bus.data_valid),  32'h0);
        check("mr_mean", 32'(bus.block_mean),  32'h0);
        check("mr_vcnt", 32'(bus.block_v_cnt), 32'h0);
        check("mr_mode", 32'(bus.mode_active), 32'h0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        send_white(8'h80, 6'd13, 1'b1, 24'h808080);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding, required 0", exp_q.size());
        end
        repeat (2) tick();
        check("hold_mean", 32'(bus.block_mean),  32'h808080);
        check("hold_vcnt", 32'(bus.block_v_cnt), 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
